// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher session controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xor_cipher_pkg;

  localparam int KEY_SIZE_DEF = 32;
  localparam int MSG_SIZE_DEF = 512;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_MSG = 3'd2,
    ST_ENCRYPT  = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  // One extra bit above the largest phase length, so a count can never wrap.
  function automatic int cnt_width(input int msg_size, input int timeout);
    return $clog2((msg_size > timeout) ? msg_size : timeout) + 1;
  endfunction

endpackage

// File: rtl/xor_session_ctrl_seq_counter.sv
// Phase bit counter with synchronous clear and terminal-count compare.
// Latency: count updates on the edge after en; tc is combinational from the count.
// Backpressure: none; holds its value whenever en and clr are both low.
module seq_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Count register: clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/xor_session_ctrl.sv
// Sequences one XOR-cipher session: key load, message load, encrypt, output wait.
// Latency: strobes are combinational from state; state moves one edge after its condition.
// Backpressure: ena low freezes state and counter and masks all strobes.
module xor_session_ctrl
  import xor_cipher_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_DEF,
  parameter int MSG_SIZE = MSG_SIZE_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       iStart,
  input  logic       iAbort,
  input  logic       iSerial_end,
  output logic       oLoad_key,
  output logic       oLoad_msg,
  output logic       oEncrypt_go,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic [2:0] oState
);

  localparam int CW = cnt_width(MSG_SIZE, TIMEOUT);

  state_t        state;
  state_t        state_nxt;
  logic          cnt_clr;
  logic          cnt_inc;
  logic [CW-1:0] tc_val;
  logic          tc;
  logic          start_armed;

  seq_counter #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ena & cnt_clr),
    .en     (ena & cnt_inc),
    .tc_val (tc_val),
    .tc     (tc)
  );

  // Terminal count for the phase currently being counted.
  always_comb begin
    tc_val = '0;
    case (state)
      ST_LOAD_KEY: tc_val = CW'(KEY_SIZE - 1);
      ST_LOAD_MSG: tc_val = CW'(MSG_SIZE - 1);
      ST_WAIT_OUT: tc_val = CW'(TIMEOUT - 1);
      default:     tc_val = '0;
    endcase
  end

  // A start held high across reset must not launch a session: wait to see it low first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_armed <= 1'b0;
    end else if (ena && !iStart) begin
      start_armed <= 1'b1;
    end
  end

  // State register; only enabled cycles advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // Next state and counter control; abort overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (iAbort) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart && start_armed) begin
            state_nxt = ST_LOAD_KEY;
            cnt_clr   = 1'b1;
          end
        end
        ST_LOAD_KEY: begin
          if (tc) begin
            state_nxt = ST_LOAD_MSG;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_LOAD_MSG: begin
          if (tc) begin
            state_nxt = ST_ENCRYPT;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_ENCRYPT: begin
          state_nxt = ST_WAIT_OUT;
          cnt_clr   = 1'b1;
        end
        ST_WAIT_OUT: begin
          // Serializer completion beats a timeout landing in the same cycle.
          if (iSerial_end) begin
            state_nxt = ST_DONE;
            cnt_clr   = 1'b1;
          end else if (tc) begin
            state_nxt = ST_ERROR;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end
        ST_ERROR: begin
          state_nxt = ST_ERROR;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  assign oLoad_key   = ena && (state == ST_LOAD_KEY);
  assign oLoad_msg   = ena && (state == ST_LOAD_MSG);
  assign oEncrypt_go = ena && (state == ST_ENCRYPT);
  assign oDone       = ena && (state == ST_DONE);
  assign oBusy       = (state != ST_IDLE) && (state != ST_ERROR);
  assign oError      = (state == ST_ERROR);
  assign oState      = state;

endmodule

// File: tb/tb_xor_session_ctrl.sv
module tb_xor_session_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       iStart = 1'b0;
  logic       iAbort = 1'b0;
  logic       iSerial_end = 1'b0;
  logic       oLoad_key, oLoad_msg, oEncrypt_go, oBusy, oDone, oError;
  logic [2:0] oState;

  int tests = 0;
  int fails = 0;
  int n_key = 0, n_msg = 0, n_enc = 0, n_done = 0, n_overlap = 0;

  always #5 clk = ~clk;

  xor_session_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .iStart      (iStart),
    .iAbort      (iAbort),
    .iSerial_end (iSerial_end),
    .oLoad_key   (oLoad_key),
    .oLoad_msg   (oLoad_msg),
    .oEncrypt_go (oEncrypt_go),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oError      (oError),
    .oState      (oState)
  );

  // Strobe-activity monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (oLoad_key === 1'b1) n_key++;
      if (oLoad_msg === 1'b1) n_msg++;
      if (oEncrypt_go === 1'b1) n_enc++;
      if (oDone === 1'b1) n_done++;
      if (oLoad_key === 1'b1 && oLoad_msg === 1'b1) n_overlap++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name, output int n);
    n = 0;
    while (oState !== s && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (oState !== s) begin
      fails++;
      $display("FAIL %s: oState=%0d required %0d after %0d cycles", name, oState, s, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; iStart = 1'b1;
    #3;
    tests++;
    if ({oLoad_key, oLoad_msg, oEncrypt_go, oBusy, oDone, oError, oState} !== 9'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 0", {oLoad_key, oLoad_msg, oEncrypt_go, oBusy, oDone, oError, oState});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (oState !== 3'd0) begin
      fails++;
      $display("FAIL fresh_start: oState=%0d required 0 with iStart held over reset", oState);
    end
    iStart = 1'b0;
    tick();
    start_session();
    tests++;
    if (oState !== 3'd1 || oBusy !== 1'b1 || oLoad_key !== 1'b1) begin
      fails++;
      $display("FAIL start_after_reset: state=%0d busy=%b load_key=%b required 1/1/1", oState, oBusy, oLoad_key);
    end
    iAbort = 1'b1; tick(); iAbort = 1'b0;
    tests++;
    if (oState !== 3'd0) begin
      fails++;
      $display("FAIL abort_key: oState=%0d required 0", oState);
    end
  endtask

  task automatic test_session();
    int k0, m0, e0, d0;
    k0 = n_key; m0 = n_msg; e0 = n_enc; d0 = n_done;
    start_session();
    repeat (31) tick();
    tests++;
    if (oState !== 3'd1) begin fails++; $display("FAIL key_len_last: oState=%0d required 1", oState); end
    tick();
    tests++;
    if (oState !== 3'd2) begin fails++; $display("FAIL key_to_msg: oState=%0d required 2", oState); end
    repeat (511) tick();
    tests++;
    if (oState !== 3'd2) begin fails++; $display("FAIL msg_len_last: oState=%0d required 2", oState); end
    tick();
    tests++;
    if (oState !== 3'd3 || oEncrypt_go !== 1'b1) begin
      fails++; $display("FAIL encrypt: oState=%0d go=%b required 3/1", oState, oEncrypt_go);
    end
    tick();
    tests++;
    if (oState !== 3'd4 || oEncrypt_go !== 1'b0) begin
      fails++; $display("FAIL enter_wait: oState=%0d go=%b required 4/0", oState, oEncrypt_go);
    end
    tests++;
    if (n_key - k0 != 32 || n_msg - m0 != 512 || n_enc - e0 != 1) begin
      fails++; $display("FAIL strobe_counts: key=%0d msg=%0d enc=%0d required 32/512/1", n_key - k0, n_msg - m0, n_enc - e0);
    end
    repeat (99) tick();
    iSerial_end = 1'b1; tick(); iSerial_end = 1'b0;
    tests++;
    if (oState !== 3'd5 || oDone !== 1'b1) begin
      fails++; $display("FAIL done: oState=%0d oDone=%b required 5/1", oState, oDone);
    end
    tick();
    tests++;
    if (oState !== 3'd0 || oBusy !== 1'b0 || oDone !== 1'b0 || n_done - d0 != 1) begin
      fails++; $display("FAIL after_done: state=%0d busy=%b done=%b pulses=%0d required 0/0/0/1", oState, oBusy, oDone, n_done - d0);
    end
  endtask

  task automatic test_timeout();
    int n, cnt;
    start_session();
    wait_state(3'd4, 700, "timeout_reach_wait", n);
    cnt = 0;
    while (oState === 3'd4 && cnt < 2000) begin tick(); cnt++; end
    tests++;
    if (oState !== 3'd6 || cnt != 1024) begin
      fails++; $display("FAIL timeout_len: state=%0d wait_cycles=%0d required 6/1024", oState, cnt);
    end
    tests++;
    if (oError !== 1'b1 || oBusy !== 1'b0) begin
      fails++; $display("FAIL error_flags: oError=%b oBusy=%b required 1/0", oError, oBusy);
    end
    iStart = 1'b1; tick(); iStart = 1'b0;
    tests++;
    if (oState !== 3'd6 || oError !== 1'b1) begin
      fails++; $display("FAIL error_ignores_start: state=%0d oError=%b required 6/1", oState, oError);
    end
    iAbort = 1'b1; tick(); iAbort = 1'b0;
    tests++;
    if (oState !== 3'd0 || oError !== 1'b0) begin
      fails++; $display("FAIL error_abort: state=%0d oError=%b required 0/0", oState, oError);
    end
  endtask

  task automatic test_ena_gap();
    int k0, n, gap_bad;
    k0 = n_key;
    gap_bad = 0;
    start_session();
    repeat (15) tick();
    ena = 1'b0;
    repeat (10) begin
      #1;
      if (oLoad_key !== 1'b0 || oState !== 3'd1) gap_bad++;
      tick();
    end
    ena = 1'b1;
    tests++;
    if (gap_bad != 0) begin fails++; $display("FAIL ena_gap_hold: %0d bad cycles required 0", gap_bad); end
    wait_state(3'd2, 100, "ena_gap_reach_msg", n);
    tests++;
    if (n != 17 || n_key - k0 != 32) begin
      fails++; $display("FAIL ena_gap_count: resume_cycles=%0d key_high=%0d required 17/32", n, n_key - k0);
    end
    iAbort = 1'b1; tick(); iAbort = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    start_session();
    wait_state(3'd2, 100, "abort_reach_msg", n);
    repeat (200) tick();
    tests++;
    if (oLoad_msg !== 1'b1) begin fails++; $display("FAIL abort_pre: oLoad_msg=%b required 1", oLoad_msg); end
    iAbort = 1'b1; tick(); iAbort = 1'b0;
    tests++;
    if (oState !== 3'd0 || oLoad_msg !== 1'b0 || oBusy !== 1'b0) begin
      fails++; $display("FAIL abort_msg: state=%0d load_msg=%b busy=%b required 0/0/0", oState, oLoad_msg, oBusy);
    end
    start_session();
    wait_state(3'd2, 100, "reset_reach_msg", n);
    repeat (300) tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({oLoad_key, oLoad_msg, oEncrypt_go, oBusy, oDone, oError, oState} !== 9'b0) begin
      fails++; $display("FAIL midsession_reset: got %b required 0", {oLoad_key, oLoad_msg, oEncrypt_go, oBusy, oDone, oError, oState});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (oState !== 3'd0) begin fails++; $display("FAIL post_reset_idle: oState=%0d required 0", oState); end
  endtask

  task automatic test_race();
    int n;
    start_session();
    wait_state(3'd4, 700, "race_reach_wait", n);
    repeat (1023) tick();
    tests++;
    if (oState !== 3'd4) begin fails++; $display("FAIL race_pre: oState=%0d required 4", oState); end
    iSerial_end = 1'b1; tick(); iSerial_end = 1'b0;
    tests++;
    if (oState !== 3'd5 || oError !== 1'b0) begin
      fails++; $display("FAIL race_done: state=%0d oError=%b required 5/0", oState, oError);
    end
    tick();
  endtask

  task automatic test_random();
    int d, w, bad, it, k0, m0, e0, exp_w;
    logic [2:0] exp_st;
    for (int s = 0; s < 4; s++) begin
      d = (s == 3) ? 1050 : int'($urandom_range(0, 1100));
      exp_st = (d <= 1023) ? 3'd5 : 3'd6;
      exp_w  = (d <= 1023) ? d + 1 : 1024;
      k0 = n_key; m0 = n_msg; e0 = n_enc;
      w = 0; bad = 0; it = 0;
      ena = 1'b1;
      start_session();
      while (oState !== 3'd5 && oState !== 3'd6 && it < 8000) begin
        ena = ($urandom_range(0, 3) != 0);
        iStart = 1'($urandom_range(0, 1));
        iSerial_end = (oState === 3'd4 && w == d);
        #1;
        if (!ena && (oLoad_key || oLoad_msg || oEncrypt_go || oDone)) bad++;
        if (ena && oState === 3'd4) w++;
        tick();
        it++;
      end
      ena = 1'b1; iStart = 1'b0; iSerial_end = 1'b0;
      tests++;
      if (oState !== exp_st || w != exp_w) begin
        fails++; $display("FAIL rand_end[%0d]: state=%0d wait=%0d required %0d/%0d (d=%0d)", s, oState, w, exp_st, exp_w, d);
      end
      tests++;
      if (bad != 0 || n_key - k0 != 32 || n_msg - m0 != 512 || n_enc - e0 != 1) begin
        fails++; $display("FAIL rand_strobes[%0d]: masked_bad=%0d key=%0d msg=%0d enc=%0d required 0/32/512/1", s, bad, n_key - k0, n_msg - m0, n_enc - e0);
      end
      if (oState === 3'd6) begin
        iAbort = 1'b1; tick(); iAbort = 1'b0;
      end else begin
        tick();
      end
      tests++;
      if (oState !== 3'd0) begin fails++; $display("FAIL rand_idle[%0d]: oState=%0d required 0", s, oState); end
    end
  endtask

  task automatic test_exclusive();
    tests++;
    if (n_overlap != 0) begin
      fails++; $display("FAIL load_exclusive: %0d overlap cycles required 0", n_overlap);
    end
  endtask

  initial begin
    test_reset();
    test_session();
    test_timeout();
    test_ena_gap();
    test_abort();
    test_race();
    test_random();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
